// File: rtl/spr_pkg.sv
// Shared SPR indices, cause bit positions and sequencer state encoding
// for the interrupt/ERET controller of the special-purpose register file.
package spr_pkg;

    localparam logic [2:0] SPR_SR    = 3'd0;
    localparam logic [2:0] SPR_ESR   = 3'd1;
    localparam logic [2:0] SPR_ECA   = 3'd2;
    localparam logic [2:0] SPR_EPC   = 3'd3;
    localparam logic [2:0] SPR_EDATA = 3'd4;
    localparam logic [2:0] SPR_MODE  = 3'd7;

    localparam int CA_RESET    = 0;
    localparam int CA_ILL      = 1;
    localparam int CA_MAL      = 2;
    localparam int CA_PFF      = 3;
    localparam int CA_PFLS     = 4;
    localparam int CA_SYS      = 5;
    localparam int CA_OVF      = 6;
    localparam int CA_EXT_BASE = 7;

    localparam int N_CA  = 23;
    localparam int N_NMI = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_ERET_RD,
        ST_ERET_WR,
        ST_ERET_PC
    } spr_state_e;

endpackage

// File: rtl/cause_prio_enc.sv
// Lowest-set-bit encoder over the masked cause vector; bit 0 wins.
// Purely combinational, no backpressure.
module cause_prio_enc
    import spr_pkg::*;
(
    input  logic [N_CA-1:0] i_vec,
    output logic [4:0]      o_ecode,
    output logic            o_vld
);

    always_comb begin
        o_ecode = '0;
        o_vld   = 1'b0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = N_CA - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_ecode = 5'(i);
                o_vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spr_ctrl.sv
// Interrupt sequencer and SPR port arbiter: takes interrupts with a same-cycle jisr,
// flushes afterwards, runs the 3-cycle ERET restore, else passes pipe SPR traffic through.
module spr_ctrl
    import spr_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int N_EXT        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inst_valid,
    input  logic [6:0]       int_cause,
    input  logic [N_EXT-1:0] ext_irq,
    input  logic [31:0]      sr,
    input  logic             eret,
    input  logic [2:0]       pipe_spr_sel,
    input  logic             pipe_sprw,
    input  logic [31:0]      pipe_spr_wdata,
    input  logic [31:0]      spr_rdata,
    output logic             jisr,
    output logic [6+N_EXT:0] mca,
    output logic             rpt,
    output logic [4:0]       ecode,
    output logic             flush,
    output logic             stall_pipe,
    output logic [2:0]       spr_sel,
    output logic             sprw,
    output logic [31:0]      spr_wdata,
    output logic [N_EXT-1:0] ext_ack,
    output logic             eret_redirect,
    output logic [31:0]      epc
);

    localparam int CW  = $clog2(FLUSH_CYCLES + 1);
    localparam int NCA = 7 + N_EXT;

    spr_state_e       r_state;
    logic [N_EXT-1:0] r_pend;
    logic [CW-1:0]    r_cnt;
    logic [31:0]      r_esr_hold;

    logic [NCA-1:0]   w_mca;
    logic [4:0]       w_ecode;
    logic             w_any;
    logic             w_take;
    logic [N_EXT-1:0] w_ack;
    logic             w_unused_sr;

    // Causes below N_NMI ignore SR; the rest are gated by the matching SR bit.
    assign w_mca       = {r_pend, int_cause} & {sr[NCA-1:N_NMI], {N_NMI{1'b1}}};
    assign w_unused_sr = ^{sr[31:NCA], sr[N_NMI-1:0]};

    cause_prio_enc u_enc (
        .i_vec   (w_mca),
        .o_ecode (w_ecode),
        .o_vld   (w_any)
    );

    assign w_take = rst_n & (r_state == ST_IDLE) & inst_valid & w_any;
    assign w_ack  = (w_take && (w_ecode >= 5'(CA_EXT_BASE)))
                  ? (N_EXT'(1) << (w_ecode - 5'(CA_EXT_BASE))) : '0;

    assign mca     = w_mca;
    assign ecode   = w_ecode;
    assign rpt     = w_any & ((w_ecode == 5'(CA_PFF)) | (w_ecode == 5'(CA_PFLS)));
    assign jisr    = w_take;
    assign ext_ack = w_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pend     <= '0;
            r_cnt      <= '0;
            r_esr_hold <= '0;
        end else begin
            // A new request on the acked line re-arms it.
            r_pend <= (r_pend & ~w_ack) | ext_irq;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state <= ST_FLUSH;
                        r_cnt   <= CW'(FLUSH_CYCLES);
                    end else if (inst_valid && eret) begin
                        r_state <= ST_ERET_RD;
                    end
                end
                ST_FLUSH: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ERET_RD: begin
                    r_esr_hold <= spr_rdata;
                    r_state    <= ST_ERET_WR;
                end
                ST_ERET_WR: r_state <= ST_ERET_PC;
                ST_ERET_PC: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        flush         = 1'b0;
        stall_pipe    = 1'b0;
        spr_sel       = '0;
        sprw          = 1'b0;
        spr_wdata     = '0;
        eret_redirect = 1'b0;
        epc           = '0;
        case (r_state)
            ST_IDLE: begin
                spr_sel   = pipe_spr_sel;
                sprw      = pipe_sprw;
                spr_wdata = pipe_spr_wdata;
            end
            ST_FLUSH: begin
                flush = 1'b1;
            end
            ST_ERET_RD: begin
                stall_pipe = 1'b1;
                spr_sel    = SPR_ESR;
            end
            ST_ERET_WR: begin
                stall_pipe = 1'b1;
                spr_sel    = SPR_SR;
                sprw       = 1'b1;
                spr_wdata  = r_esr_hold;
            end
            ST_ERET_PC: begin
                stall_pipe    = 1'b1;
                spr_sel       = SPR_EPC;
                eret_redirect = 1'b1;
                epc           = spr_rdata;
                flush         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/spr_ctrl.md
Name: spr_ctrl

Overview:
- Interrupt/exception sequencer and port arbiter for the 8-entry special-purpose register file (SR=0, ESR=1, ECA=2, EPC=3, EDATA=4, MODE=7).
- Latches external interrupt requests and masks all causes against SR. When an interrupt is taken it drives jisr/mca/rpt and flushes the pipe.
- Runs the ERET restore sequence (ESR->SR, EPC->PC redirect). Outside these sequences it muxes pipeline SPR reads and writes straight through to the SPR file port.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays asserted after jisr (>=1)
- N_EXT, 16, external interrupt lines; fixed so that 7+N_EXT = 23 = mca width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid  in  1  instruction in the commit stage is valid
- int_cause  in  7  internal causes: [0]reset [1]ill [2]mal [3]pff [4]pfls [5]sys [6]ovf
- ext_irq  in  N_EXT  external request lines (level or pulse)
- sr  in  32  current SR from the SPR file (mask bits)
- eret  in  1  commit-stage instruction is ERET
- pipe_spr_sel  in  3  pipeline SPR index
- pipe_sprw  in  1  pipeline SPR write enable
- pipe_spr_wdata  in  32  pipeline SPR write data
- spr_rdata  in  32  SPR file read data for spr_sel
- jisr  out  1  jump-to-ISR pulse to the SPR file and PC logic
- mca  out  23  masked cause vector
- rpt  out  1  repeat-type interrupt (EPC=pc rather than next_pc)
- ecode  out  5  index of the serviced cause
- flush  out  1  kill in-flight instructions
- stall_pipe  out  1  hold the pipeline
- spr_sel  out  3  SPR file select
- sprw  out  1  SPR file write enable
- spr_wdata  out  32  SPR file write data
- ext_ack  out  N_EXT  one-hot acknowledge of the serviced external line
- eret_redirect  out  1  PC := epc this cycle
- epc  out  32  restore PC

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pend=0, flush counter=0, esr_hold=0.
  - All outputs are 0, except that IDLE passthrough values (spr_sel, sprw, spr_wdata from the pipe inputs) remain visible.
- Pending latch:
  - pend <= (pend & ~ext_ack) | ext_irq, every cycle in every state. Set wins over ack on the same bit.
- Cause vector:
  - ca = {pend, int_cause}.
  - mca[i] = ca[i] for i<6 (non-maskable); mca[i] = ca[i] & sr[i] for 6..22.
  - mca is combinational and always driven.
- ecode:
  - Index of the lowest set bit of mca (bit 0 = highest priority); 0 when mca==0.
  - rpt = (mca!=0) & (ecode==3 | ecode==4).
- States: IDLE, FLUSH, ERET_RD, ERET_WR, ERET_PC.
- IDLE:
  - Take interrupt when inst_valid & |mca.
  - On take: jisr=1 for exactly this cycle, with mca/rpt/ecode valid in the same cycle.
  - On take: ext_ack[ecode-7]=1 if ecode>=7, otherwise ext_ack=0.
  - On take: go to FLUSH with counter=FLUSH_CYCLES.
  - Else if inst_valid & eret: go to ERET_RD. jisr has priority over eret in the same cycle.
  - In IDLE: spr_sel, sprw, spr_wdata = pipe_* passthrough; stall_pipe=0.
- FLUSH:
  - flush=1, stall_pipe=0, sprw=0.
  - Counter decrements each cycle; at 1, go to IDLE. Flush is therefore high for FLUSH_CYCLES cycles starting the cycle after jisr.
  - No new jisr is taken in FLUSH; causes remain pending.
- ERET_RD:
  - stall_pipe=1, spr_sel=1, sprw=0.
  - esr_hold <= spr_rdata; go to ERET_WR.
- ERET_WR:
  - stall_pipe=1, spr_sel=0, sprw=1, spr_wdata=esr_hold; go to ERET_PC.
- ERET_PC:
  - stall_pipe=1, spr_sel=3, eret_redirect=1, epc=spr_rdata, flush=1; go to IDLE.
- Pipe SPR inputs outside IDLE are ignored. The pipe is stalled in the ERET states and flushed in FLUSH.
- Interrupts are never taken outside IDLE. A cause unmasked by the ERET SR write is taken in IDLE on the next valid instruction.
- inst_valid=0 in IDLE: no jisr, no eret; pend is held.
- rst_n asserted mid-sequence: immediate return to IDLE; any partially completed ERET is abandoned with no SR write.

Decomposition:
- Shared package spr_pkg:
  - SPR index constants (SPR_SR=0, SPR_ESR=1, SPR_ECA=2, SPR_EPC=3, SPR_EDATA=4, SPR_MODE=7).
  - Cause bit constants (CA_RESET..CA_OVF, CA_EXT_BASE=7).
  - State enum typedef.
- One sub-module: cause_prio_enc, 23-bit lowest-set-bit encoder producing ecode and a valid flag.

Test Plan:
- inst_valid=1, int_cause=7'b0000100 (mal), sr=0 -> same cycle jisr=1, mca=23'h4, ecode=2, rpt=0; flush=1 for the next 2 cycles; then IDLE.
- ext_irq[0] pulsed 1 cycle with sr[7]=0; after 3 cycles set sr[7]=1 with inst_valid=1 -> jisr with ecode=7, ext_ack=16'h0001; pend[0]=0 the next cycle.
- int_cause[3] (pff) and int_cause[6] both set, sr[6]=1 -> ecode=3, rpt=1, mca=23'h48.
- eret=1, inst_valid=1, ESR=32'h0000_0080, EPC=32'h0000_1000 -> ERET_RD (spr_sel=1), ERET_WR (sprw=1, spr_sel=0, wdata=32'h80), ERET_PC (eret_redirect=1, epc=32'h1000); stall_pipe high for 3 cycles.
- eret=1 and int_cause[1]=1 in the same cycle -> jisr=1, ecode=1, no ERET states entered.
- rst_n=0 asserted during ERET_WR -> outputs zero asynchronously, state IDLE, pend=0; after release, pipe_sprw=1 and pipe_spr_sel=2 pass through to sprw/spr_sel.
